// File: rtl/rib_dmem_slave_if.sv
// rtl/rib_dmem_slave_if.sv - memory-request bus between EX/MEM register and data-memory responder
// Optional macro RIB_DMEM_ERR_EN adds the err_o response flag.
interface rib_dmem_slave_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] raddr_i;
  logic [31:0] waddr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        hold_req_o;
  logic        busy_o;
`ifdef RIB_DMEM_ERR_EN
  logic        err_o;
`endif

  modport master (
    output req_i, we_i, raddr_i, waddr_i, wdata_i,
`ifdef RIB_DMEM_ERR_EN
    input  err_o,
`endif
    input  rdata_o, ack_o, hold_req_o, busy_o
  );

  modport slave (
    input  req_i, we_i, raddr_i, waddr_i, wdata_i,
`ifdef RIB_DMEM_ERR_EN
    output err_o,
`endif
    output rdata_o, ack_o, hold_req_o, busy_o
  );
endinterface

// File: rtl/rib_dmem_slave.sv
// rtl/rib_dmem_slave.sv - word-RAM data-memory responder with programmable wait states
// Optional macro RIB_DMEM_ERR_EN flags out-of-range addresses instead of aliasing them.
module rib_dmem_slave #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  rib_dmem_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic        commit;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && bus.req_i) begin
        lat_we    <= bus.we_i;
        lat_addr  <= bus.we_i ? bus.waddr_i : bus.raddr_i;
        lat_wdata <= bus.wdata_i;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_i) begin
          cnt_n   = 4'(LATENCY);
          state_n = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // live inputs must be used rather than the not-yet-latched copies.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_we    = bus.we_i;
      cur_addr  = bus.we_i ? bus.waddr_i : bus.raddr_i;
      cur_wdata = bus.wdata_i;
    end
  end

  assign commit = rst && (state != RESP) && (state_n == RESP);
  assign idx    = cur_addr[AW+1:2];

`ifdef RIB_DMEM_ERR_EN
  assign cur_err    = |cur_addr[31:AW+2];
  assign bus.err_o  = (state == RESP) && (|lat_addr[31:AW+2]);
  wire   unused_bits = ^cur_addr[1:0];
`else
  assign cur_err     = 1'b0;
  wire   unused_bits = ^{cur_addr[31:AW+2], cur_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_err) mem[idx] <= cur_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (commit && (!cur_we || cur_err)) begin
      rdata_q <= cur_err ? '0 : mem[idx];
    end
  end

  assign bus.rdata_o    = rdata_q;
  assign bus.ack_o      = (state == RESP);
  assign bus.busy_o     = (state != IDLE);
  assign bus.hold_req_o = rst && ((state == IDLE && bus.req_i) || state == WAIT);
endmodule

// File: tb/tb_rib_dmem_slave.sv
// tb/tb_rib_dmem_slave.sv - randomized bench for rib_dmem_slave at LATENCY 2, 0 and 3
// Build with RIB_DMEM_ERR_EN defined to also exercise the err_o path.
module tb_rib_dmem_slave;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rib_dmem_slave_if bus0 ();
  rib_dmem_slave_if bus1 ();
  rib_dmem_slave_if bus2 ();

  rib_dmem_slave #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  rib_dmem_slave #(.DEPTH(DEPTH), .LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  rib_dmem_slave #(.DEPTH(DEPTH), .LATENCY(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic        req   [3];
  logic        we    [3];
  logic [31:0] raddr [3];
  logic [31:0] waddr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        hold  [3];
  logic        busy  [3];

  assign bus0.req_i = req[0];  assign bus0.we_i = we[0];
  assign bus0.raddr_i = raddr[0]; assign bus0.waddr_i = waddr[0]; assign bus0.wdata_i = wdata[0];
  assign bus1.req_i = req[1];  assign bus1.we_i = we[1];
  assign bus1.raddr_i = raddr[1]; assign bus1.waddr_i = waddr[1]; assign bus1.wdata_i = wdata[1];
  assign bus2.req_i = req[2];  assign bus2.we_i = we[2];
  assign bus2.raddr_i = raddr[2]; assign bus2.waddr_i = waddr[2]; assign bus2.wdata_i = wdata[2];

  assign rdata[0] = bus0.rdata_o; assign ack[0] = bus0.ack_o;
  assign hold[0]  = bus0.hold_req_o; assign busy[0] = bus0.busy_o;
  assign rdata[1] = bus1.rdata_o; assign ack[1] = bus1.ack_o;
  assign hold[1]  = bus1.hold_req_o; assign busy[1] = bus1.busy_o;
  assign rdata[2] = bus2.rdata_o; assign ack[2] = bus2.ack_o;
  assign hold[2]  = bus2.hold_req_o; assign busy[2] = bus2.busy_o;

`ifdef RIB_DMEM_ERR_EN
  logic err [3];
  assign err[0] = bus0.err_o;
  assign err[1] = bus1.err_o;
  assign err[2] = bus2.err_o;
`endif

  int checks = 0;
  int passes = 0;

  logic [31:0] mem_m [int];
  logic [31:0] last_rd [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    return k * DEPTH + int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit is_err(input logic [31:0] a);
`ifdef RIB_DMEM_ERR_EN
    return (a >> ($clog2(DEPTH) + 2)) != 0;
`else
    return (a == 32'h0) && (a != 32'h0);
`endif
  endfunction

  // Caller is just past a rising edge with the DUT idle.
  task automatic access(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit keep);
    int          n;
    bit          e;
    logic [31:0] exp_rd;
    e = is_err(a);
    req[k] = 1'b1; we[k] = w; wdata[k] = d;
    if (w) begin waddr[k] = a; raddr[k] = $urandom; end
    else   begin raddr[k] = a; waddr[k] = $urandom; end
    #1;
    check("hold_idle_req", 32'(hold[k]), 32'd1);
    check("ack_early", 32'(ack[k]), 32'd0);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack[k]) break;
      check("hold_wait", 32'(hold[k]), 32'd1);
      check("busy_wait", 32'(busy[k]), 32'd1);
    end
    check("ack_latency", 32'(n), 32'(lat_of(k) + 1));
    check("hold_resp", 32'(hold[k]), 32'd0);
`ifdef RIB_DMEM_ERR_EN
    check("err_resp", 32'(err[k]), 32'(e));
`endif
    if (e) begin
      if (!w) check("rdata_err", rdata[k], 32'h0);
      last_rd[k] = 32'h0;
    end else if (w) begin
      mem_m[key(k, a)] = d;
    end else begin
      exp_rd = mem_m[key(k, a)];
      check("rdata", rdata[k], exp_rd);
      last_rd[k] = exp_rd;
    end
    if (!keep) req[k] = 1'b0;
    @(posedge clk); #1;
    if (!keep) begin
      check("ack_idle", 32'(ack[k]), 32'd0);
      check("hold_idle", 32'(hold[k]), 32'd0);
      check("busy_idle", 32'(busy[k]), 32'd0);
      check("rdata_hold", rdata[k], last_rd[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] prior;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; we[i] = 1'b0; raddr[i] = 32'h10; waddr[i] = 32'h10; wdata[i] = 32'h0;
      last_rd[i] = 32'h0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", 32'(ack[i]), 32'd0);
      check("rst_hold", 32'(hold[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_rdata", rdata[i], 32'h0);
    end
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++)
      for (int j = 0; j <= 16; j++)
        access(i, 1'b1, 32'(j * 4), $urandom, 1'b0);

    access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("read_after_write", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 32'h0000_0022, 32'h1122_3344, 1'b0);
    access(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    check("misaligned_alias", rdata[0], 32'h1122_3344);

    access(1, 1'b0, 32'h0, 32'h0, 1'b1);
    access(1, 1'b0, 32'h4, 32'h0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      k = int'($urandom % 3);
      a = 32'(($urandom % 17) * 4) | 32'($urandom % 4);
`ifndef RIB_DMEM_ERR_EN
      a = a | ($urandom << 14);
`endif
      access(k, 1'($urandom % 2), a, $urandom, 1'b0);
    end

    prior = mem_m[key(2, 32'h40)];
    req[2] = 1'b1; we[2] = 1'b1; waddr[2] = 32'h40; raddr[2] = 32'h0; wdata[2] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("midwait_busy", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midwait_rst_hold", 32'(hold[2]), 32'd0);
    check("midwait_rst_busy", 32'(busy[2]), 32'd0);
    check("midwait_rst_rdata", rdata[2], 32'h0);
    @(posedge clk); #1;
    check("midwait_rst_ack", 32'(ack[2]), 32'd0);
    req[2] = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    @(posedge clk); #1;
    check("midwait_no_ack", 32'(ack[2]), 32'd0);
    access(2, 1'b0, 32'h40, 32'h0, 1'b0);
    check("midwait_discard", rdata[2], prior);

`ifdef RIB_DMEM_ERR_EN
    prior = mem_m[key(0, 32'h0)];
    access(0, 1'b1, 32'h0001_0000, 32'h55AA_55AA, 1'b0);
    access(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    check("err_no_write", rdata[0], prior);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
